fetch_stage: RTL and testbench

//   Instruction-fetch stage; sits directly upstream of the decode stage (its IF/ID register).

---
 rtl/fetch_stage.sv | 84 ++++++++
 tb/tb_fetch_stage.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: PC and instruction fetch with a prefetch buffer feeding the decode stage
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter int          BUF_DEPTH = 2,
  parameter logic [15:0] NOP_INSTR = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        jump,
  input  logic [15:0] new_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [15:0] imem_rdata,
  output logic [15:0] pc_out,
  output logic [15:0] ir_out,
  output logic [15:0] IPCP2,
  output logic        valid_out
);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, KILL} state_t;
  state_t state, state_n;
  logic [15:0] fetch_pc, req_pc;
  logic [15:0] buf_pc [BUF_DEPTH];
  logic [15:0] buf_ir [BUF_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic accept, push, pop;
  assign imem_req  = reset && state == IDLE && count < FULL;
  assign imem_addr = fetch_pc;
  assign accept    = imem_req && imem_ready;
  assign push      = state == WAIT && imem_rvalid && !jump;
  assign valid_out = count != '0;
  assign pop       = valid_out && !stall && !jump;
  assign pc_out    = valid_out ? buf_pc[rd_ptr] : '0;
  assign ir_out    = valid_out ? buf_ir[rd_ptr] : NOP_INSTR;
  assign IPCP2     = pc_out + 16'd2;
  // next state: a redirect with a request still in flight waits out the stale response in KILL
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = accept ? (jump ? KILL : WAIT) : IDLE;
      WAIT:    state_n = imem_rvalid ? IDLE : (jump ? KILL : WAIT);
      KILL:    state_n = imem_rvalid ? IDLE : KILL;
      default: state_n = IDLE;
    endcase
  end
  // state, PC and buffer bookkeeping; a redirect flushes the buffer and overrides pop/push
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      state <= state_n;
      if (accept) req_pc <= fetch_pc;
      if (jump) fetch_pc <= {new_pc[15:1], 1'b0};
      else if (accept) fetch_pc <= fetch_pc + 16'd2;
      if (jump) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end
  // entry storage; unreset because entries are only read while counted valid
  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc[wr_ptr] <= req_pc;
      buf_ir[wr_ptr] <= imem_rdata;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of fetch_stage against hand-computed values
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        reset = 1'b0, stall = 1'b0, jump = 1'b0;
  logic [15:0] new_pc = '0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready = 1'b1, imem_rvalid = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic [15:0] pc_out, ir_out, IPCP2;
  logic        valid_out;
  int          n_cmp = 0, n_bad = 0, n_acc = 0, lat = 1, dly = 0;
  logic        outst = 1'b0, dead_next = 1'b0;
  logic [15:0] out_addr = '0;

  fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .jump(jump), .new_pc(new_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .pc_out(pc_out), .ir_out(ir_out), .IPCP2(IPCP2), .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem(input logic [15:0] a);
    return a == 16'h0000 ? 16'h1111 : a == 16'h0002 ? 16'h2222 : a ^ 16'h5A00;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic acc;
    logic [15:0] a;
    logic rst_edge;
    #1;
    acc = imem_req && imem_ready;
    a = imem_addr;
    rst_edge = !reset;
    @(posedge clk);
    @(negedge clk);
    imem_rvalid = 1'b0;
    if (rst_edge) outst = 1'b0;
    else if (acc) begin
      n_acc++;
      outst = 1'b1;
      out_addr = a;
      dly = lat;
    end
    if (outst) begin
      if (dly <= 1) begin
        imem_rvalid = 1'b1;
        imem_rdata = dead_next ? 16'hDEAD : mem(out_addr);
        dead_next = 1'b0;
        outst = 1'b0;
      end else dly--;
    end
  endtask

  initial begin
    tick();
    tick();
    chk("rst_req", 16'(imem_req), 16'h0);
    chk("rst_valid", 16'(valid_out), 16'h0);
    chk("rst_ir", ir_out, 16'h0000);
    chk("rst_pc", pc_out, 16'h0000);
    chk("rst_ipcp2", IPCP2, 16'h0002);
    reset = 1'b1;
    #1;
    chk("first_req", 16'(imem_req), 16'h1);
    chk("first_addr", imem_addr, 16'h0000);
    tick();
    chk("wait_req", 16'(imem_req), 16'h0);
    tick();
    chk("i0_valid", 16'(valid_out), 16'h1);
    chk("i0_pc", pc_out, 16'h0000);
    chk("i0_ir", ir_out, 16'h1111);
    chk("i0_ipcp2", IPCP2, 16'h0002);
    chk("i1_addr", imem_addr, 16'h0002);
    tick();
    chk("i0_popped", 16'(valid_out), 16'h0);
    tick();
    chk("i1_pc", pc_out, 16'h0002);
    chk("i1_ir", ir_out, 16'h2222);
    chk("i1_ipcp2", IPCP2, 16'h0004);
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("nrdy_req", 16'(imem_req), 16'h1);
      chk("nrdy_addr", imem_addr, 16'h0004);
    end
    chk("nrdy_empty", 16'(valid_out), 16'h0);
    imem_ready = 1'b1;
    stall = 1'b1;
    n_acc = 0;
    for (int i = 0; i < 6; i++) tick();
    chk("stall_fetches", 16'(n_acc), 16'h0002);
    chk("stall_req", 16'(imem_req), 16'h0);
    chk("stall_head_pc", pc_out, 16'h0004);
    chk("stall_head_ir", ir_out, 16'h5A04);
    stall = 1'b0;
    tick();
    chk("drain_pc", pc_out, 16'h0006);
    chk("drain_ir", ir_out, 16'h5A06);
    lat = 3;
    dead_next = 1'b1;
    tick();
    chk("drain_empty", 16'(valid_out), 16'h0);
    chk("drain_wait_req", 16'(imem_req), 16'h0);
    jump = 1'b1;
    new_pc = 16'h0041;
    tick();
    jump = 1'b0;
    chk("kill_valid", 16'(valid_out), 16'h0);
    chk("kill_req", 16'(imem_req), 16'h0);
    tick();
    chk("kill_req2", 16'(imem_req), 16'h0);
    tick();
    chk("kill_discard", 16'(valid_out), 16'h0);
    chk("redir_req", 16'(imem_req), 16'h1);
    chk("redir_addr", imem_addr, 16'h0040);
    lat = 1;
    tick();
    tick();
    chk("redir_valid", 16'(valid_out), 16'h1);
    chk("redir_pc", pc_out, 16'h0040);
    chk("redir_ir", ir_out, 16'h5A40);
    jump = 1'b1;
    new_pc = 16'hFFFE;
    tick();
    jump = 1'b0;
    chk("jacc_flush", 16'(valid_out), 16'h0);
    chk("jacc_req", 16'(imem_req), 16'h0);
    tick();
    chk("wrap_req", 16'(imem_req), 16'h1);
    chk("wrap_addr", imem_addr, 16'hFFFE);
    chk("wrap_empty", 16'(valid_out), 16'h0);
    tick();
    chk("wrap_next_addr", imem_addr, 16'h0000);
    tick();
    chk("wrap_pc", pc_out, 16'hFFFE);
    chk("wrap_ir", ir_out, 16'hA5FE);
    chk("wrap_ipcp2", IPCP2, 16'h0000);
    stall = 1'b1;
    lat = 3;
    tick();
    chk("pre_rst_req", 16'(imem_req), 16'h0);
    chk("pre_rst_valid", 16'(valid_out), 16'h1);
    reset = 1'b0;
    tick();
    chk("mid_rst_valid", 16'(valid_out), 16'h0);
    chk("mid_rst_ir", ir_out, 16'h0000);
    chk("mid_rst_pc", pc_out, 16'h0000);
    chk("mid_rst_ipcp2", IPCP2, 16'h0002);
    chk("mid_rst_addr", imem_addr, 16'h0000);
    reset = 1'b1;
    stall = 1'b0;
    lat = 1;
    #1;
    chk("post_rst_req", 16'(imem_req), 16'h1);
    tick();
    tick();
    chk("post_rst_pc", pc_out, 16'h0000);
    chk("post_rst_ir", ir_out, 16'h1111);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
